instr_align_fetch: RTL
======================

# instr_align_fetch

Fetch and alignment controller that sits between instruction memory and the RVC decompressor. It fetches 32-bit words and tracks a halfword-granular PC. It extracts the next 16- or 32-bit instruction, including instructions that straddle a word boundary, and presents it with a `decompress` flag that drives the decompressor's `decompress_i`. It buffers one leftover halfword so that two compressed instructions packed in one word issue back-to-back with a single memory access.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC of the first instruction after reset; bit 0 must be 0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  32  word-aligned fetch address; bits [1:0] always 0.
- `imem_ack`  in  1  fetch done; `imem_rdata` is valid in this cycle.
- `imem_rdata`  in  32  fetched word, little-endian halfwords.
- `redirect_i`  in  1  branch/jump redirect; one-cycle pulse.
- `redirect_pc_i`  in  32  redirect target; bit 0 is ignored.
- `stall_i`  in  1  downstream not ready; the held instruction is not consumed.
- `valid_o`  out  1  `instr_o`, `decompress_o` and `pc_o` are valid.
- `instr_o`  out  32  raw instruction; for compressed instructions this is {16'h0, halfword}.
- `decompress_o`  out  1  1 when `instr_o[1:0]` != 2'b11, i.e. a compressed instruction.
- `pc_o`  out  32  byte address of the presented instruction.

## Operation
Internal state:
- `fpc`: word fetch address.
- `buf`/`buf_v`: leftover upper halfword.
- `skip`: discard the low half of the next fetched word.
- `hold`: a 32-bit instruction's low half is waiting in `buf`.

States:
- **FETCH**
  - `imem_req`=1, `imem_addr`=`fpc`.
  - On `imem_ack`, with fetched word W:
    - `skip`=1: load `buf`=W[31:16] at `pc+2`, clear `skip`.
      - If that halfword is compressed, issue it and go to ISSUE.
      - Otherwise stay in FETCH with `fpc`+4.
    - `buf_v`=1 holding the low half of a 32-bit instruction: issue {W[15:0], buf}, then `buf`=W[31:16], `buf_v`=1.
    - Otherwise, if W[1:0]!=11: issue {16'h0, W[15:0]}, then `buf`=W[31:16], `buf_v`=1.
    - Otherwise: issue W, `buf_v`=0.
    - `fpc` advances by 4 on every ack.
- **ISSUE**
  - Output register valid.
  - On acceptance (`valid_o` & !`stall_i`):
    - If `buf_v` and `buf[1:0]`!=11: issue {16'h0, `buf`}, clear `buf_v`, stay in ISSUE.
    - Otherwise go to FETCH. `buf_v` stays set if `buf` holds a 32-bit low half.
- **PC update:** the PC of each issued instruction equals the previous PC + 2 (compressed) or + 4. Arithmetic is mod 2^32; wrap-around from 32'hFFFF_FFFE to 0 is legal.
- **Redirect** (any state, highest priority):
  - `valid_o`←0, `buf_v`←0.
  - `fpc`←{`redirect_pc_i`[31:2], 2'b00}, `skip`←`redirect_pc_i`[1].
  - Next state FETCH.
  - An `imem_ack` arriving in the redirect cycle is discarded.
- **Stall:** while `stall_i`=1 and `valid_o`=1, all outputs are held stable. A pending fetch may complete into the buffer, but no new instruction is issued.
- **Illegal encodings:** all 16-bit encodings, including 16'h0000, are passed through unchanged. Legality is checked downstream.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC` word, `valid_o`=0, `instr_o`=0, `decompress_o`=0, `pc_o`=`RESET_PC`. State is FETCH, `buf_v`=0, `skip`=`RESET_PC`[1] (0 for a legal `RESET_PC`).
- **After reset:** `imem_req` rises in the first cycle after `rst` deasserts.
- **Fetch latency:** `valid_o` rises one cycle after `imem_ack`. All outputs are registered.
- **Buffered compressed instruction:** issues in the cycle after the previous instruction is accepted, with no bubble and no memory access.
- **Straddling 32-bit instruction:** costs one extra fetch.
- **Redirect:** `imem_req` with the new address in the cycle after `redirect_i`. First `valid_o` no earlier than 2 cycles after `redirect_i`.
- **Reset mid-fetch:** all state clears immediately. A late `imem_ack` after reset, while `imem_req`=0, is ignored.

## Configuration
- `INSTR_ALIGN_RVC_EN` defined:
  - Full behaviour above.
- `INSTR_ALIGN_RVC_EN` undefined:
  - The buffer and the `skip`/`hold` logic are removed.
  - Every fetched word issues as a 32-bit instruction.
  - `decompress_o` is tied to 0.
  - `redirect_pc_i`[1] is ignored (treated as 0).
  - PC always advances by 4.

## Test plan
- **Single 32-bit instruction:** reset with word@0=32'h00A00093 -> `imem_addr`=0, then after ack `valid_o`=1, `instr_o`=32'h00A00093, `decompress_o`=0, `pc_o`=0.
- **Packed compressed pair:** word@0=32'h85AA0505 -> issues 32'h00000505 @pc 0, then 32'h000085AA @pc 2 in consecutive cycles. Exactly one ack is consumed before the next fetch of 4.
- **Straddle:** word@0=32'h00930505, word@4=32'h000100A0 -> issues 32'h00000505 @0, then 32'h00A00093 @2 after the fetch of 4, then 32'h00000001 @6.
- **Odd-halfword redirect:** `redirect_i` with 32'h0000_0102, word@0x100=32'h85AA0505 -> `imem_addr`=0x100, issues 32'h000085AA @0x102, then fetches 0x104.
- **Stall:** `stall_i`=1 for 5 cycles while `valid_o`=1 -> `instr_o`/`pc_o` unchanged; after release, the next instruction follows one cycle later (if it comes from the buffer).
- **Redirect vs ack:** `redirect_i` and `imem_ack` in the same cycle -> the ack data is never issued, and the next `imem_addr` equals the redirect word address.

Source files
------------

// File: rtl/instr_align_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_align_fetch
// Description : Instruction fetch and alignment controller placed between the
//               instruction memory and the RVC decompressor. Fetches 32-bit
//               words, tracks a halfword-granular PC and presents one 16- or
//               32-bit instruction at a time, including instructions that
//               straddle a word boundary. The leftover upper halfword of a
//               fetched word is buffered so that two packed compressed
//               instructions issue back-to-back from a single fetch.
//
//               Build option: define INSTR_ALIGN_RVC_EN to enable compressed
//               instruction support. Without it every fetched word issues as
//               a 32-bit instruction, decompress_o is tied low and the PC
//               always advances by 4.
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               imem_req/addr     - word fetch request and address
//               imem_ack/rdata    - fetch completion and fetched word
//               redirect_i/pc_i   - branch/jump redirect pulse and target
//               stall_i           - downstream not ready
//               valid_o, instr_o, decompress_o, pc_o - presented instruction
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_align_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic        decompress_o,
    output logic [31:0] pc_o
);

    localparam logic [0:0] c_st_fetch = 1'b0;
    localparam logic [0:0] c_st_issue = 1'b1;

    logic [0:0]  r_state;
    logic        r_req;
    logic [31:0] r_fpc;
    logic [31:0] r_next_pc;   // PC of the next instruction to be issued
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    logic        w_ack;
    logic        w_accept;
    logic        w_iss;       // an instruction is loaded into the output register
    logic [31:0] w_iss_instr;
    logic        w_iss_c;     // the loaded instruction is compressed
    logic [31:0] w_step;

    // An ack is only meaningful while a request is outstanding; this drops
    // stray acks arriving after reset or while presenting an instruction.
    assign w_ack    = (r_state == c_st_fetch) & r_req & imem_ack;
    assign w_accept = r_valid & ~stall_i;

`ifdef INSTR_ALIGN_RVC_EN
    logic [15:0] r_buf;
    logic        r_buf_v;
    logic        r_skip;
    logic        r_decomp;
    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic        w_hold;      // buffer holds the low half of a 32-bit instruction
    logic        w_buf_c;     // buffer holds a complete compressed instruction
    logic        w_unused_redirect;

    assign w_lo    = imem_rdata[15:0];
    assign w_hi    = imem_rdata[31:16];
    assign w_hold  = r_buf_v & (r_buf[1:0] == 2'b11);
    assign w_buf_c = r_buf_v & (r_buf[1:0] != 2'b11);
    assign w_unused_redirect = redirect_pc_i[0];
`else
    logic        w_unused_redirect;
    assign w_unused_redirect = ^redirect_pc_i[1:0];
`endif

    always_comb begin
        w_iss       = 1'b0;
        w_iss_instr = imem_rdata;
        if (r_state == c_st_fetch) begin
            if (w_ack) begin
`ifdef INSTR_ALIGN_RVC_EN
                if (r_skip) begin
                    // Entered mid-word: only the upper half belongs to the
                    // stream. A 32-bit low half waits for the next word.
                    w_iss       = (w_hi[1:0] != 2'b11);
                    w_iss_instr = {16'h0000, w_hi};
                end else if (w_hold) begin
                    w_iss       = 1'b1;
                    w_iss_instr = {w_lo, r_buf};
                end else if (w_lo[1:0] != 2'b11) begin
                    w_iss       = 1'b1;
                    w_iss_instr = {16'h0000, w_lo};
                end else begin
                    w_iss       = 1'b1;
                    w_iss_instr = imem_rdata;
                end
`else
                w_iss       = 1'b1;
                w_iss_instr = imem_rdata;
`endif
            end
        end else begin
`ifdef INSTR_ALIGN_RVC_EN
            // Second compressed instruction of a packed word: issue it
            // straight from the buffer without touching memory.
            if (w_accept && w_buf_c) begin
                w_iss       = 1'b1;
                w_iss_instr = {16'h0000, r_buf};
            end
`endif
        end
    end

`ifdef INSTR_ALIGN_RVC_EN
    assign w_iss_c = (w_iss_instr[1:0] != 2'b11);
`else
    assign w_iss_c = 1'b0;
`endif
    assign w_step = w_iss_c ? 32'd2 : 32'd4;

    // Main sequencer: fetch address, request, PC and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_fetch;
            r_req     <= 1'b0;
            r_fpc     <= {RESET_PC[31:2], 2'b00};
`ifdef INSTR_ALIGN_RVC_EN
            r_next_pc <= {RESET_PC[31:1], 1'b0};
`else
            r_next_pc <= {RESET_PC[31:2], 2'b00};
`endif
            r_valid   <= 1'b0;
            r_instr   <= 32'h0000_0000;
            r_pc      <= RESET_PC;
        end else if (redirect_i) begin
            r_state   <= c_st_fetch;
            r_req     <= 1'b1;
            r_fpc     <= {redirect_pc_i[31:2], 2'b00};
`ifdef INSTR_ALIGN_RVC_EN
            r_next_pc <= {redirect_pc_i[31:1], 1'b0};
`else
            r_next_pc <= {redirect_pc_i[31:2], 2'b00};
`endif
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (w_ack) begin
                        r_fpc <= r_fpc + 32'd4;
                    end
                    if (w_iss) begin
                        r_state <= c_st_issue;
                        r_req   <= 1'b0;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept && !w_iss) begin
                        r_state <= c_st_fetch;
                        r_req   <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
            endcase
            if (w_iss) begin
                r_valid   <= 1'b1;
                r_instr   <= w_iss_instr;
                r_pc      <= r_next_pc;
                r_next_pc <= r_next_pc + w_step;
            end
        end
    end

`ifdef INSTR_ALIGN_RVC_EN
    // Halfword buffer and mid-word entry tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf    <= 16'h0000;
            r_buf_v  <= 1'b0;
            r_skip   <= RESET_PC[1];
            r_decomp <= 1'b0;
        end else if (redirect_i) begin
            r_buf_v  <= 1'b0;
            r_skip   <= redirect_pc_i[1];
        end else begin
            if (r_state == c_st_fetch) begin
                if (w_ack) begin
                    r_buf <= w_hi;
                    if (r_skip) begin
                        r_skip  <= 1'b0;
                        r_buf_v <= (w_hi[1:0] == 2'b11);
                    end else if (w_hold || (w_lo[1:0] != 2'b11)) begin
                        r_buf_v <= 1'b1;
                    end else begin
                        r_buf_v <= 1'b0;
                    end
                end
            end else if (w_accept && w_buf_c) begin
                r_buf_v <= 1'b0;
            end
            if (w_iss) begin
                r_decomp <= w_iss_c;
            end
        end
    end

    assign decompress_o = r_decomp;
`else
    assign decompress_o = 1'b0;
`endif

    assign imem_req  = r_req;
    assign imem_addr = r_fpc;
    assign valid_o   = r_valid;
    assign instr_o   = r_instr;
    assign pc_o      = r_pc;

endmodule
`default_nettype wire
